// File: rtl/axis_slave_rx_buffer_if.sv
// rtl/axis_slave_rx_buffer_if.sv - AXI4-Stream bundle between a stream master and the rx buffer
interface axis_slave_rx_buffer_if #(
  parameter int NUM_BYTES = 4,
  parameter int ID_W      = 8,
  parameter int DEST_W    = 4,
  parameter int USER_W    = 17
);
  logic                   TVALID;
  logic                   TREADY;
  logic [8*NUM_BYTES-1:0] TDATA;
  logic [NUM_BYTES-1:0]   TSTRB;
  logic [NUM_BYTES-1:0]   TKEEP;
  logic                   TLAST;
  logic [ID_W-1:0]        TID;
  logic [DEST_W-1:0]      TDEST;
  logic [USER_W-1:0]      TUSER;

  modport master (
    output TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
    input  TREADY
  );

  modport slave (
    input  TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER,
    output TREADY
  );
endinterface

// File: rtl/axis_slave_rx_buffer.sv
// rtl/axis_slave_rx_buffer.sv - AXIS slave endpoint: FWFT buffer, backpressure modes, byte accounting
module axis_slave_rx_buffer #(
  parameter int NUM_BYTES = 4,
  parameter int DEPTH     = 8,
  parameter int ID_W      = 8,
  parameter int DEST_W    = 4,
  parameter int USER_W    = 17,
  parameter int CNT_W     = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  axis_slave_rx_buffer_if.slave      s_axis,
  input  logic [1:0]                 bp_mode,
  input  logic [3:0]                 bp_hold,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [8*NUM_BYTES-1:0]     rd_data,
  output logic [NUM_BYTES-1:0]       rd_keep,
  output logic [NUM_BYTES-1:0]       rd_strb,
  output logic                       rd_last,
  output logic [ID_W-1:0]            rd_id,
  output logic [DEST_W-1:0]          rd_dest,
  output logic [USER_W-1:0]          rd_user,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       pkt_done,
  output logic [CNT_W-1:0]           pkt_bytes,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic                       err_strb,
  input  logic                       err_clr
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int KW = $clog2(NUM_BYTES + 1);
  localparam int SW = CNT_W + 1;
  localparam logic [PW-1:0]    PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef struct packed {
    logic [8*NUM_BYTES-1:0] data;
    logic [NUM_BYTES-1:0]   keep;
    logic [NUM_BYTES-1:0]   strb;
    logic                   last;
    logic [ID_W-1:0]        id;
    logic [DEST_W-1:0]      dest;
    logic [USER_W-1:0]      user;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            wr_entry;
  entry_t            head_vis;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              tready_q, tready_d;
  logic              toggle_q, toggle_d;
  logic [3:0]        hold_q, hold_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic [CNT_W-1:0]  pkt_bytes_q, pkt_bytes_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              pkt_done_q, pkt_done_d;
  logic              err_q, err_d;

  logic              push, pop, gate;
  logic [KW-1:0]     keep_cnt;
  logic [SW-1:0]     sum_ext;
  logic [CNT_W-1:0]  sum_sat;

  assign wr_entry = '{data: s_axis.TDATA, keep: s_axis.TKEEP, strb: s_axis.TSTRB,
                      last: s_axis.TLAST, id: s_axis.TID, dest: s_axis.TDEST,
                      user: s_axis.TUSER};

  // Head of the buffer; fields read as zero while the buffer is empty
  assign rd_valid = (level_q != '0);
  assign head_vis = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rd_data  = head_vis.data;
  assign rd_keep  = head_vis.keep;
  assign rd_strb  = head_vis.strb;
  assign rd_last  = head_vis.last;
  assign rd_id    = head_vis.id;
  assign rd_dest  = head_vis.dest;
  assign rd_user  = head_vis.user;

  assign s_axis.TREADY = tready_q;
  assign level         = level_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_bytes     = pkt_bytes_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_strb      = err_q;

  // Number of valid bytes in the offered beat
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      keep_cnt = keep_cnt + KW'(s_axis.TKEEP[i]);
    end
  end

  // Next-state: buffer pointers, backpressure gate, packet accounting, error flag
  always_comb begin
    push = s_axis.TVALID && tready_q;
    pop  = rd_en && (level_q != '0);

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);

    toggle_d = ~toggle_q;
    if (push) begin
      hold_d = bp_hold;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 4'd1;
    end else begin
      hold_d = hold_q;
    end

    case (bp_mode)
      2'd1:    gate = toggle_d;
      2'd2:    gate = (hold_d == '0);
      default: gate = 1'b1;
    endcase
    tready_d = (level_d < LW'(DEPTH)) && gate;

    // Running byte count saturates rather than wrapping
    sum_ext = {1'b0, run_q} + SW'(keep_cnt);
    sum_sat = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];

    run_d       = run_q;
    pkt_bytes_d = pkt_bytes_q;
    pkt_cnt_d   = pkt_cnt_q;
    pkt_done_d  = 1'b0;
    if (push) begin
      if (s_axis.TLAST) begin
        pkt_bytes_d = sum_sat;
        run_d       = '0;
        pkt_done_d  = 1'b1;
        pkt_cnt_d   = pkt_cnt_q + CNT_ONE;
      end else begin
        run_d = sum_sat;
      end
    end

    // A new violation outranks a clear in the same cycle
    if (push && ((s_axis.TSTRB & ~s_axis.TKEEP) != '0)) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Control and accounting registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tready_q    <= 1'b0;
      toggle_q    <= 1'b0;
      hold_q      <= '0;
      run_q       <= '0;
      pkt_bytes_q <= '0;
      pkt_cnt_q   <= '0;
      pkt_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      tready_q    <= tready_d;
      toggle_q    <= toggle_d;
      hold_q      <= hold_d;
      run_q       <= run_d;
      pkt_bytes_q <= pkt_bytes_d;
      pkt_cnt_q   <= pkt_cnt_d;
      pkt_done_q  <= pkt_done_d;
      err_q       <= err_d;
    end
  end

  // Beat storage; contents are meaningless until covered by level
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_axis_slave_rx_buffer.sv
// tb/tb_axis_slave_rx_buffer.sv - self-checking bench for axis_slave_rx_buffer
module tb_axis_slave_rx_buffer;

  localparam int NB = 4, DEPTH = 8, IDW = 8, DSW = 4, UW = 17, CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic ACLK, ARESETn;
  logic [1:0] bp_mode;
  logic [3:0] bp_hold;
  logic rd_en, rd_valid, rd_last, pkt_done, err_strb, err_clr;
  logic [8*NB-1:0] rd_data;
  logic [NB-1:0] rd_keep, rd_strb;
  logic [IDW-1:0] rd_id;
  logic [DSW-1:0] rd_dest;
  logic [UW-1:0] rd_user;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic [CW-1:0] pkt_bytes, pkt_cnt;

  axis_slave_rx_buffer_if #(.NUM_BYTES(NB), .ID_W(IDW), .DEST_W(DSW), .USER_W(UW)) axis ();

  axis_slave_rx_buffer #(.NUM_BYTES(NB), .DEPTH(DEPTH), .ID_W(IDW), .DEST_W(DSW),
                         .USER_W(UW), .CNT_W(CW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_axis(axis),
    .bp_mode(bp_mode), .bp_hold(bp_hold), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_keep(rd_keep), .rd_strb(rd_strb), .rd_last(rd_last),
    .rd_id(rd_id), .rd_dest(rd_dest), .rd_user(rd_user), .level(level),
    .pkt_done(pkt_done), .pkt_bytes(pkt_bytes), .pkt_cnt(pkt_cnt),
    .err_strb(err_strb), .err_clr(err_clr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        last;
    logic [7:0]  id;
    logic [3:0]  dest;
    logic [16:0] user;
  } beat_t;

  typedef struct {
    bit tvalid;
    bit rd_en;
    bit exp_tready;
    int exp_level;
  } vec_t;

  // Reference model state
  beat_t mq[$];
  bit m_tready, m_toggle, m_done, m_err, last_push;
  int m_hold, m_run, m_pbytes, m_pcnt;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tready = 0; m_toggle = 0; m_done = 0; m_err = 0; last_push = 0;
    m_hold = 0; m_run = 0; m_pbytes = 0; m_pcnt = 0;
  endtask

  // Rules applied at one rising edge, using the inputs present at that edge
  task automatic model_edge();
    bit push, pop, gate;
    int tot;
    beat_t b;
    push = axis.TVALID && m_tready;
    pop  = rd_en && (mq.size() != 0);
    b = '{data: axis.TDATA, keep: axis.TKEEP, strb: axis.TSTRB, last: axis.TLAST,
          id: axis.TID, dest: axis.TDEST, user: axis.TUSER};
    if (push && ((axis.TSTRB & ~axis.TKEEP) != 0)) m_err = 1;
    else if (err_clr) m_err = 0;
    m_done = 0;
    if (push) begin
      tot = m_run + $countones(axis.TKEEP);
      if (tot > CNT_MAX) tot = CNT_MAX;
      if (axis.TLAST) begin
        m_pbytes = tot; m_run = 0; m_done = 1; m_pcnt = (m_pcnt + 1) % (CNT_MAX + 1);
      end else begin
        m_run = tot;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(b);
    m_toggle = !m_toggle;
    m_hold = push ? int'(bp_hold) : (m_hold > 0 ? m_hold - 1 : 0);
    case (bp_mode)
      2'd1:    gate = m_toggle;
      2'd2:    gate = (m_hold == 0);
      default: gate = 1;
    endcase
    m_tready = (mq.size() < DEPTH) && gate;
    last_push = push;
  endtask

  task automatic compare_all();
    chk("tready", axis.TREADY, m_tready);
    chk("level", level, mq.size());
    chk("rd_valid", rd_valid, mq.size() != 0);
    chk("pkt_done", pkt_done, m_done);
    chk("pkt_bytes", pkt_bytes, m_pbytes);
    chk("pkt_cnt", pkt_cnt, m_pcnt);
    chk("err_strb", err_strb, m_err);
    if (mq.size() != 0) begin
      chk("rd_data", rd_data, mq[0].data);
      chk("rd_keep", rd_keep, mq[0].keep);
      chk("rd_strb", rd_strb, mq[0].strb);
      chk("rd_last", rd_last, mq[0].last);
      chk("rd_id", rd_id, mq[0].id);
      chk("rd_dest", rd_dest, mq[0].dest);
      chk("rd_user", rd_user, mq[0].user);
    end
  endtask

  task automatic cycle();
    @(posedge ACLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                          input logic l);
    axis.TDATA = d; axis.TKEEP = k; axis.TSTRB = s; axis.TLAST = l;
    axis.TID = d[15:8]; axis.TDEST = d[3:0]; axis.TUSER = d[16:0] ^ 17'h15555;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                           input logic l);
    int n = 0;
    set_beat(d, k, s, l);
    axis.TVALID = 1;
    do begin
      cycle();
      n++;
    end while (!last_push && n < 20);
    if (!last_push) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: beat 0x%0h not accepted within %0d cycles", d, n);
    end
    axis.TVALID = 0;
  endtask

  // Asynchronous assertion a little after an edge; release mid-cycle
  task automatic do_reset();
    #2;
    ARESETn = 0;
    #1;
    chk("rst_tready", axis.TREADY, 0);
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_bytes", pkt_bytes, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_strb", err_strb, 0);
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[12];
    int seq, prev, nacc;

    tbl[0]  = '{1, 0, 1, 0};
    tbl[1]  = '{1, 0, 1, 1};
    tbl[2]  = '{1, 0, 1, 2};
    tbl[3]  = '{1, 0, 1, 3};
    tbl[4]  = '{1, 0, 1, 4};
    tbl[5]  = '{1, 0, 1, 5};
    tbl[6]  = '{1, 0, 1, 6};
    tbl[7]  = '{1, 0, 1, 7};
    tbl[8]  = '{1, 0, 0, 8};
    tbl[9]  = '{1, 0, 0, 8};
    tbl[10] = '{1, 1, 1, 7};
    tbl[11] = '{1, 0, 0, 8};

    ARESETn = 0; bp_mode = 0; bp_hold = 0; rd_en = 0; err_clr = 0;
    axis.TVALID = 0;
    set_beat(32'h0, 4'h0, 4'h0, 1'b0);
    model_reset();

    // Fill to full, then one pop re-opens TREADY for the 9th beat
    do_reset();
    seq = 0;
    set_beat(32'hA000_0000, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 12; i++) begin
      axis.TVALID = tbl[i].tvalid;
      rd_en = tbl[i].rd_en;
      cycle();
      chk($sformatf("tbl%0d_tready", i), axis.TREADY, tbl[i].exp_tready);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_level);
      if (last_push) begin
        seq++;
        set_beat(32'hA000_0000 + seq, 4'hF, 4'hF, 1'b0);
      end
    end
    axis.TVALID = 0; rd_en = 1;
    repeat (9) cycle();
    chk("drain_level", level, 0);

    // Packet byte accounting F,F,3 then a fresh one-beat packet
    do_reset();
    rd_en = 1;
    send_beat(32'h1111_0001, 4'hF, 4'hF, 1'b0);
    send_beat(32'h1111_0002, 4'hF, 4'hF, 1'b0);
    send_beat(32'h1111_0003, 4'h3, 4'h3, 1'b1);
    chk("pkt1_done", pkt_done, 1);
    chk("pkt1_bytes", pkt_bytes, 10);
    chk("pkt1_cnt", pkt_cnt, 1);
    cycle();
    chk("pkt1_done_pulse", pkt_done, 0);
    send_beat(32'h1111_0004, 4'h1, 4'h1, 1'b1);
    chk("pkt2_bytes", pkt_bytes, 1);
    chk("pkt2_cnt", pkt_cnt, 2);

    // Hold-off mode: one acceptance every bp_hold+1 cycles
    bp_mode = 2; bp_hold = 3;
    do_reset();
    rd_en = 1; axis.TVALID = 1; prev = -1; nacc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_push) begin
        if (prev >= 0) chk("mode2_gap", i - prev, 4);
        prev = i; nacc++;
        set_beat($urandom, 4'hF, 4'hF, 1'b0);
      end
    end
    chk("mode2_count", nacc, 10);

    // Alternate mode: one acceptance every 2 cycles
    bp_mode = 1; bp_hold = 0;
    do_reset();
    rd_en = 1; axis.TVALID = 1; prev = -1; nacc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (last_push) begin
        if (prev >= 0) chk("mode1_gap", i - prev, 2);
        prev = i; nacc++;
        set_beat($urandom, 4'hF, 4'hF, 1'b0);
      end
    end
    chk("mode1_count", nacc, 20);
    axis.TVALID = 0;

    // Sticky strobe error, clear, and set-beats-clear
    bp_mode = 0;
    do_reset();
    rd_en = 1;
    send_beat(32'h2222_0001, 4'b0010, 4'b0110, 1'b0);
    chk("err_set", err_strb, 1);
    send_beat(32'h2222_0002, 4'hF, 4'hF, 1'b0);
    chk("err_sticky", err_strb, 1);
    err_clr = 1;
    cycle();
    err_clr = 0;
    chk("err_clear", err_strb, 0);
    err_clr = 1;
    send_beat(32'h2222_0003, 4'b0001, 4'b1001, 1'b1);
    err_clr = 0;
    chk("err_set_wins", err_strb, 1);

    // Simultaneous push/pop at level 4, then pop while empty
    do_reset();
    rd_en = 0;
    for (int i = 0; i < 4; i++) send_beat(32'h3333_0000 + i, 4'hF, 4'hF, 1'b0);
    chk("pp_level_pre", level, 4);
    set_beat(32'h3333_0010, 4'hF, 4'hF, 1'b0);
    axis.TVALID = 1; rd_en = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("pp_level", level, 4);
      if (last_push) set_beat(32'h3333_0011 + i, 4'hF, 4'hF, 1'b0);
    end
    axis.TVALID = 0;
    repeat (4) cycle();
    chk("pp_drained", level, 0);
    cycle();
    chk("empty_pop_level", level, 0);
    chk("empty_pop_valid", rd_valid, 0);

    // Reset mid-packet at level 5 discards buffered beats and partial count
    do_reset();
    rd_en = 0;
    send_beat(32'h4444_0000, 4'hF, 4'hF, 1'b1);
    send_beat(32'h4444_0001, 4'hF, 4'hF, 1'b0);
    send_beat(32'h4444_0002, 4'h1, 4'h3, 1'b0);
    send_beat(32'h4444_0003, 4'hF, 4'hF, 1'b0);
    send_beat(32'h4444_0004, 4'hF, 4'hF, 1'b0);
    chk("mid_level", level, 5);
    chk("mid_err", err_strb, 1);
    do_reset();
    rd_en = 1;
    send_beat(32'h4444_0010, 4'hF, 4'hF, 1'b0);
    send_beat(32'h4444_0011, 4'hF, 4'hF, 1'b1);
    chk("post_rst_bytes", pkt_bytes, 8);
    chk("post_rst_cnt", pkt_cnt, 1);

    // Randomized traffic against the reference model
    for (int seg = 0; seg < 8; seg++) begin
      bp_mode = 2'($urandom_range(0, 3));
      bp_hold = 4'($urandom_range(0, 4));
      for (int i = 0; i < 200; i++) begin
        logic [3:0] k, s;
        k = 4'($urandom);
        s = ($urandom_range(0, 9) == 0) ? 4'($urandom) : k;
        set_beat($urandom, k, s, $urandom_range(0, 3) == 0);
        axis.TVALID = ($urandom_range(0, 99) < 70);
        rd_en = ($urandom_range(0, 99) < 55);
        err_clr = ($urandom_range(0, 19) == 0);
        cycle();
      end
    end
    err_clr = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
